// File: rtl/random_param_gen.sv
`default_nettype none
// ============================================================================
//  Module   : random_param_gen
//  Purpose  : Supplies a random run time and turn angle to the motion-decision
//             FSM. A free-running 16-bit Galois LFSR is rejection-sampled into
//             RandomTime (TIME_MIN..TIME_MAX) and RandomAngle (0..ANGLE_MAX).
//             The pair is drawn ahead of time and held stable until consumed
//             by RandomLoad, then a fresh pair is drawn.
//  Ports    : clk          in   1       system clock, rising edge
//             rst          in   1       asynchronous reset, ACTIVE-LOW
//             RandomLoad   in   1       consume strobe
//             RandomTime   out  10      drawn run time
//             RandomAngle  out  10      drawn turn angle
//             rand_valid   out  1       outputs hold a fresh, unconsumed pair
//             rand_overrun out  1       sticky: RandomLoad seen while not valid
//             seed_load    in   1       (RANDOM_SEED_LOAD_EN only) reseed strobe
//             seed_in      in   LFSR_W  (RANDOM_SEED_LOAD_EN only) new seed
//  Options  : define RANDOM_SEED_LOAD_EN to add the run-time reseed ports.
//  Revision : 1.0  initial release
// ============================================================================
module random_param_gen #(
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter logic [9:0]        TIME_MIN  = 10'd8,
    parameter logic [9:0]        TIME_MAX  = 10'd1000,
    parameter logic [9:0]        ANGLE_MAX = 10'd359,
    parameter int                MAX_TRIES = 8
) (
    input  logic              clk,
    input  logic              rst,
`ifdef RANDOM_SEED_LOAD_EN
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
`endif
    input  logic              RandomLoad,
    output logic [9:0]        RandomTime,
    output logic [9:0]        RandomAngle,
    output logic              rand_valid,
    output logic              rand_overrun
);

    localparam int                c_TRIES_W  = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    // Galois feedback mask for x^16+x^14+x^13+x^11+1 (right-shifting form).
    localparam logic [LFSR_W-1:0] c_TAP_MASK = LFSR_W'(16'hB400);
    localparam logic [c_TRIES_W-1:0] c_LAST_TRY = c_TRIES_W'(MAX_TRIES - 1);

    typedef enum logic [1:0] {
        ST_DRAW_T = 2'd0,
        ST_DRAW_A = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    state_t                 r_state_q,   w_state_d;
    logic [LFSR_W-1:0]      r_lfsr_q,    w_lfsr_d;
    logic [c_TRIES_W-1:0]   r_tries_q,   w_tries_d;
    logic [9:0]             r_time_q,    w_time_d;
    logic [9:0]             r_angle_q,   w_angle_d;
    logic                   r_valid_q,   w_valid_d;
    logic                   r_overrun_q, w_overrun_d;

    logic [9:0]             w_sample;
    logic [LFSR_W-1:0]      w_lfsr_adv;
    logic                   w_last_try;

    always_comb begin
        // The sample is the register value before this cycle's advance.
        w_sample   = r_lfsr_q[9:0];
        // An all-zero LFSR is the lock-up state; recover by reloading SEED.
        if (r_lfsr_q == '0) begin
            w_lfsr_adv = SEED;
        end else begin
            w_lfsr_adv = {1'b0, r_lfsr_q[LFSR_W-1:1]} ^ (r_lfsr_q[0] ? c_TAP_MASK : '0);
        end
        w_last_try = (r_tries_q == c_LAST_TRY);

        w_lfsr_d    = w_lfsr_adv;
        w_state_d   = r_state_q;
        w_tries_d   = r_tries_q;
        w_time_d    = r_time_q;
        w_angle_d   = r_angle_q;
        w_valid_d   = r_valid_q;
        w_overrun_d = r_overrun_q;

        case (r_state_q)
            ST_DRAW_T: begin
                if ((w_sample >= TIME_MIN) && (w_sample <= TIME_MAX)) begin
                    w_time_d  = w_sample;
                    w_tries_d = '0;
                    w_state_d = ST_DRAW_A;
                end else if (w_last_try) begin
                    // Out of attempts: clamp to the nearer bound of the last sample.
                    w_time_d  = (w_sample < TIME_MIN) ? TIME_MIN : TIME_MAX;
                    w_tries_d = '0;
                    w_state_d = ST_DRAW_A;
                end else begin
                    w_tries_d = r_tries_q + 1'b1;
                end
            end
            ST_DRAW_A: begin
                if (w_sample <= ANGLE_MAX) begin
                    w_angle_d = w_sample;
                    w_tries_d = '0;
                    w_valid_d = 1'b1;
                    w_state_d = ST_READY;
                end else if (w_last_try) begin
                    w_angle_d = ANGLE_MAX;
                    w_tries_d = '0;
                    w_valid_d = 1'b1;
                    w_state_d = ST_READY;
                end else begin
                    w_tries_d = r_tries_q + 1'b1;
                end
            end
            ST_READY: begin
                // Outputs keep the consumed pair; they change only when the
                // next time sample is accepted.
                if (RandomLoad) begin
                    w_valid_d = 1'b0;
                    w_state_d = ST_DRAW_T;
                end
            end
            default: begin
                w_tries_d = '0;
                w_valid_d = 1'b0;
                w_state_d = ST_DRAW_T;
            end
        endcase

        // A consume request with nothing ready is flagged and otherwise ignored.
        if (RandomLoad && !r_valid_q) begin
            w_overrun_d = 1'b1;
        end

`ifdef RANDOM_SEED_LOAD_EN
        // Reseed overrides everything, including a simultaneous RandomLoad.
        if (seed_load) begin
            w_lfsr_d    = (seed_in == '0) ? SEED : seed_in;
            w_valid_d   = 1'b0;
            w_state_d   = ST_DRAW_T;
            w_tries_d   = '0;
            w_time_d    = r_time_q;
            w_angle_d   = r_angle_q;
            w_overrun_d = r_overrun_q;
        end
`endif
    end

    // rst is active-low and asynchronous.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr_q    <= SEED;
            r_state_q   <= ST_DRAW_T;
            r_tries_q   <= '0;
            r_time_q    <= TIME_MIN;
            r_angle_q   <= '0;
            r_valid_q   <= 1'b0;
            r_overrun_q <= 1'b0;
        end else begin
            r_lfsr_q    <= w_lfsr_d;
            r_state_q   <= w_state_d;
            r_tries_q   <= w_tries_d;
            r_time_q    <= w_time_d;
            r_angle_q   <= w_angle_d;
            r_valid_q   <= w_valid_d;
            r_overrun_q <= w_overrun_d;
        end
    end

    assign RandomTime   = r_time_q;
    assign RandomAngle  = r_angle_q;
    assign rand_valid   = r_valid_q;
    assign rand_overrun = r_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_random_param_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_random_param_gen
//  Purpose  : Self-checking bench for random_param_gen. A transaction-level
//             model predicts each drawn pair and when it lands; every cycle
//             the DUT outputs are compared with it. A second instance with
//             TIME_MIN=TIME_MAX=1000 and MAX_TRIES=2 exercises the clamp.
//  Revision : 1.0  initial release
// ============================================================================
module tb_random_param_gen;

    localparam logic [15:0] c_SEED = 16'hACE1;
    localparam int          c_TMIN = 8;
    localparam int          c_TMAX = 1000;
    localparam int          c_AMAX = 359;
    localparam int          c_MT   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       RandomLoad = 1'b0;
    logic       load2 = 1'b0;
    logic [9:0] rt, ra, rt2, ra2;
    logic       rv, ro, rv2, ro2;

    always #5 clk = ~clk;

    random_param_gen #(
        .LFSR_W(16), .SEED(c_SEED), .TIME_MIN(10'd8), .TIME_MAX(10'd1000),
        .ANGLE_MAX(10'd359), .MAX_TRIES(8)
    ) dut (
        .clk(clk), .rst(rst),
`ifdef RANDOM_SEED_LOAD_EN
        .seed_load(1'b0), .seed_in(16'h0000),
`endif
        .RandomLoad(RandomLoad), .RandomTime(rt), .RandomAngle(ra),
        .rand_valid(rv), .rand_overrun(ro)
    );

    random_param_gen #(
        .LFSR_W(16), .SEED(c_SEED), .TIME_MIN(10'd1000), .TIME_MAX(10'd1000),
        .ANGLE_MAX(10'd359), .MAX_TRIES(2)
    ) dut2 (
        .clk(clk), .rst(rst),
`ifdef RANDOM_SEED_LOAD_EN
        .seed_load(1'b0), .seed_in(16'h0000),
`endif
        .RandomLoad(load2), .RandomTime(rt2), .RandomAngle(ra2),
        .rand_valid(rv2), .rand_overrun(ro2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One LFSR step: halve, and fold in the polynomial when the dropped bit is 1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        if (v == 16'h0000) return c_SEED;
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Draw one pair from the sample stream starting at 'start': each field
    // takes up to mt samples, the first legal one wins, else clamp on the last.
    function automatic void draw_pair(input logic [15:0] start, input int tmin, input int tmax,
                                      input int amax, input int mt,
                                      output int k_t, output int t, output int k_all, output int a);
        logic [15:0] l;
        int s;
        int n;
        l = start;
        n = 0;
        t = 0;
        a = 0;
        for (int i = 0; i < mt; i++) begin
            s = int'(l[9:0]);
            l = lfsr_step(l);
            n++;
            if (s >= tmin && s <= tmax) begin
                t = s;
                break;
            end
            if (i == mt - 1) t = (s < tmin) ? tmin : tmax;
        end
        k_t = n;
        for (int i = 0; i < mt; i++) begin
            s = int'(l[9:0]);
            l = lfsr_step(l);
            n++;
            if (s <= amax) begin
                a = s;
                break;
            end
            if (i == mt - 1) a = amax;
        end
        k_all = n;
    endfunction

    // Model state
    logic [15:0] m_lfsr;
    bit          m_drawing;
    int          m_cnt, m_kt, m_kall, m_t, m_a;
    int          m_time, m_angle;
    bit          m_valid, m_overrun;

    task automatic start_draw(input logic [15:0] from);
        draw_pair(from, c_TMIN, c_TMAX, c_AMAX, c_MT, m_kt, m_t, m_kall, m_a);
        m_cnt     = 0;
        m_drawing = 1'b1;
    endtask

    task automatic model_reset();
        m_lfsr    = c_SEED;
        m_time    = c_TMIN;
        m_angle   = 0;
        m_valid   = 1'b0;
        m_overrun = 1'b0;
        start_draw(c_SEED);
    endtask

    // Advance the model across one rising edge with the given load input.
    task automatic model_edge(input bit ld);
        logic [15:0] nxt;
        nxt = lfsr_step(m_lfsr);
        if (m_drawing) begin
            if (ld) m_overrun = 1'b1;
            m_cnt++;
            if (m_cnt == m_kt) m_time = m_t;
            if (m_cnt == m_kall) begin
                m_angle   = m_a;
                m_valid   = 1'b1;
                m_drawing = 1'b0;
            end
        end else if (ld) begin
            m_valid = 1'b0;
            start_draw(nxt);
        end
        m_lfsr = nxt;
    endtask

    task automatic compare_all();
        chk("time",    32'(rt), 32'(m_time));
        chk("angle",   32'(ra), 32'(m_angle));
        chk("valid",   32'(rv), 32'(m_valid));
        chk("overrun", 32'(ro), 32'(m_overrun));
    endtask

    // Called at a falling edge: check, drive, predict, then wait one cycle.
    task automatic cycle(input bit ld);
        compare_all();
        RandomLoad = ld;
        model_edge(ld);
        @(negedge clk);
    endtask

    initial begin
        int  kt, tv, ka, av;
        bit  found;

        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_time",     32'(rt),  32'd8);
        chk("rst_angle",    32'(ra),  32'd0);
        chk("rst_valid",    32'(rv),  32'd0);
        chk("rst_overrun",  32'(ro),  32'd0);
        chk("rst2_time",    32'(rt2), 32'd1000);
        chk("rst2_valid",   32'(rv2), 32'd0);

        // Hand-derived pins on the model: ACE1 -> E270, first pair (225,312) in 3 clocks.
        chk("pin_step", 32'(lfsr_step(c_SEED)), 32'h0000E270);
        draw_pair(c_SEED, c_TMIN, c_TMAX, c_AMAX, c_MT, kt, tv, ka, av);
        chk("pin_draw_time",  32'(tv), 32'd225);
        chk("pin_draw_angle", 32'(av), 32'd312);
        chk("pin_draw_lat",   32'(ka), 32'd3);

        rst = 1'b1;
        model_reset();
        cycle(1'b0);
        chk("clamp_valid_e1", 32'(rv2), 32'd0);
        cycle(1'b0);
        chk("clamp_time_e2",  32'(rt2), 32'd1000);
        chk("clamp_valid_e2", 32'(rv2), 32'd0);
        cycle(1'b0);
        chk("clamp_valid_e3", 32'(rv2), 32'd1);
        chk("clamp_angle_e3", 32'(ra2), 32'd312);
        chk("first_time",     32'(rt),  32'd225);
        chk("first_angle",    32'(ra),  32'd312);
        chk("first_valid",    32'(rv),  32'd1);

        // Well-behaved consumer: only loads when a pair is ready.
        for (int i = 0; i < 400; i++) cycle(m_valid && ($urandom_range(0, 2) == 0));
        // Unrestricted consumer: loads at any time, exercising overrun.
        for (int i = 0; i < 400; i++) cycle($urandom_range(0, 3) == 0);

        // Reach the angle phase of a draw, then reset asynchronously.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_drawing && m_cnt >= m_kt) found = 1'b1;
            else cycle(m_valid || ($urandom_range(0, 3) == 0));
        end
        chk("midreset_reached", 32'(found), 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_time",    32'(rt), 32'd8);
        chk("midrst_angle",   32'(ra), 32'd0);
        chk("midrst_valid",   32'(rv), 32'd0);
        chk("midrst_overrun", 32'(ro), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        for (int i = 0; i < 150; i++) cycle($urandom_range(0, 2) == 0);
        compare_all();

        chk("clamp_final_time",  32'(rt2), 32'd1000);
        chk("clamp_final_angle", 32'(ra2), 32'd312);
        chk("clamp_final_valid", 32'(rv2), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
